h264intra_dcpred: RTL

H264INTRA_DCPRED -- requirements
Module: h264intra_dcpred

---
 rtl/h264intra_dcpred_pkg.sv | 49 ++++
 rtl/h264intra_dcpred_dcsum.sv | 33 +++
 rtl/h264intra_dcpred.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/h264intra_dcpred_pkg.sv
// Shared types and constants for the H.264 intra DC predictor slice.
// Holds the FSM state encoding, accumulator modes, legal block sizes and DC default.
package h264_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADT,
    S_LOADL,
    S_CALC,
    S_RESID,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ACC_HOLD,
    ACC_CLR,
    ACC_ADD4,
    ACC_ADD1
  } acc_mode_t;

  localparam int BLK_4  = 4;
  localparam int BLK_8  = 8;
  localparam int BLK_16 = 16;

  localparam logic [7:0] DC_DEFAULT = 8'd128;
  localparam int         SUM_W      = 12;
  localparam int         TOT_W      = 13;

  function automatic int blk_log2(input int blk);
    case (blk)
      BLK_4:   return 2;
      BLK_8:   return 3;
      BLK_16:  return 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic [9:0] byte_sum4(input logic [31:0] w);
    return 10'(w[7:0]) + 10'(w[15:8]) + 10'(w[23:16]) + 10'(w[31:24]);
  endfunction

  // First state after START or a channel change; unavailable loads take no cycles.
  function automatic state_t load_entry(input logic tav, input logic lav);
    if (tav)      return S_LOADT;
    else if (lav) return S_LOADL;
    else          return S_CALC;
  endfunction

endpackage

// File: rtl/h264intra_dcpred_dcsum.sv
// Neighbour-pixel accumulator: clear, add four packed bytes, or add one byte.
// Instantiated once for the top row and once for the left column.
module h264dcsum
  import h264_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  acc_mode_t        mode_i,
  input  logic [31:0]      data_i,
  output logic [SUM_W-1:0] sum_o
);

  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    case (mode_i)
      ACC_CLR:  sum_d = '0;
      ACC_ADD4: sum_d = sum_q + SUM_W'(byte_sum4(data_i));
      ACC_ADD1: sum_d = sum_q + SUM_W'(data_i[7:0]);
      default:  sum_d = sum_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/h264intra_dcpred.sv
// Intra DC predictor: sums top/left neighbours, derives the DC value per channel
// and streams 4-pixel residuals (source minus DC) with one cycle of latency.
//
// state   | meaning
// S_IDLE  | waiting for START, READYI high
// S_LOADT | accumulating BLK/4 top-neighbour words
// S_LOADL | accumulating BLK left-neighbour bytes
// S_CALC  | one cycle: DC value formed from the sums
// S_RESID | streaming BLK*BLK/4 residual words
// S_DONE  | one cycle before returning to IDLE
module h264intra_dcpred
  import h264_pkg::*;
#(
  parameter int BLK = 8,
  parameter int NCH = 2
) (
  input  logic        clk2_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        topavail_i,
  input  logic        leftavail_i,
  input  logic        tstrobe_i,
  input  logic [31:0] topi_i,
  input  logic        lstrobe_i,
  input  logic [7:0]  feedbi_i,
  input  logic        strobei_i,
  input  logic [31:0] datai_i,
  output logic        readyi_o,
  output logic        strobeo_o,
  output logic [35:0] datao_o,
  output logic        dcstrobeo_o,
  output logic [7:0]  dcdatao_o,
  output logic [31:0] baseo_o,
  output logic        cho_o
);

  localparam int               LOG2_BLK = blk_log2(BLK);
  localparam int               CNT_W    = 7;
  localparam logic [CNT_W-1:0] LAST_T   = CNT_W'(BLK / 4 - 1);
  localparam logic [CNT_W-1:0] LAST_L   = CNT_W'(BLK - 1);
  localparam logic [CNT_W-1:0] LAST_R   = CNT_W'(BLK * BLK / 4 - 1);
  localparam logic             LAST_CH  = 1'(NCH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cho_q;
  logic             tav_q;
  logic             lav_q;
  logic             strobeo_q;
  logic             dcstrobeo_q;
  logic [35:0]      datao_q;
  logic [7:0]       dc_q;

  logic [SUM_W-1:0] sum_t;
  logic [SUM_W-1:0] sum_l;
  acc_mode_t        mode_t;
  acc_mode_t        mode_l;
  logic             last_res;
  logic             chan_adv;
  logic [TOT_W-1:0] tot_d;
  logic [7:0]       dc_d;
  logic [35:0]      resid_d;

  assign last_res = (state_q == S_RESID) && strobei_i && (cnt_q == LAST_R);
  assign chan_adv = last_res && (cho_q != LAST_CH);

  // Sums are held through CALC and only cleared while idle or on a channel change.
  always_comb begin
    mode_t = ACC_HOLD;
    mode_l = ACC_HOLD;
    if ((state_q == S_IDLE) || chan_adv) begin
      mode_t = ACC_CLR;
      mode_l = ACC_CLR;
    end else begin
      if ((state_q == S_LOADT) && tstrobe_i) mode_t = ACC_ADD4;
      if ((state_q == S_LOADL) && lstrobe_i) mode_l = ACC_ADD1;
    end
  end

  h264dcsum u_sum_t (
    .clk_i  (clk2_i),
    .rst_i  (reset_i),
    .mode_i (mode_t),
    .data_i (topi_i),
    .sum_o  (sum_t)
  );

  h264dcsum u_sum_l (
    .clk_i  (clk2_i),
    .rst_i  (reset_i),
    .mode_i (mode_l),
    .data_i ({24'd0, feedbi_i}),
    .sum_o  (sum_l)
  );

  always_comb begin
    tot_d = '0;
    dc_d  = DC_DEFAULT;
    case ({tav_q, lav_q})
      2'b11: begin
        tot_d = TOT_W'(sum_t) + TOT_W'(sum_l) + TOT_W'(BLK);
        dc_d  = 8'(tot_d >> (LOG2_BLK + 1));
      end
      2'b10: begin
        tot_d = TOT_W'(sum_t) + TOT_W'(BLK / 2);
        dc_d  = 8'(tot_d >> LOG2_BLK);
      end
      2'b01: begin
        tot_d = TOT_W'(sum_l) + TOT_W'(BLK / 2);
        dc_d  = 8'(tot_d >> LOG2_BLK);
      end
      default: begin
        tot_d = '0;
        dc_d  = DC_DEFAULT;
      end
    endcase
  end

  always_comb begin
    resid_d = '0;
    for (int k = 0; k < 4; k++) begin
      resid_d[9*k +: 9] = {1'b0, datai_i[8*k +: 8]} - {1'b0, dc_q};
    end
  end

  always_ff @(posedge clk2_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cho_q       <= 1'b0;
      tav_q       <= 1'b0;
      lav_q       <= 1'b0;
      strobeo_q   <= 1'b0;
      dcstrobeo_q <= 1'b0;
      datao_q     <= '0;
      dc_q        <= DC_DEFAULT;
    end else begin
      strobeo_q   <= 1'b0;
      dcstrobeo_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (start_i) begin
            tav_q   <= topavail_i;
            lav_q   <= leftavail_i;
            cho_q   <= 1'b0;
            state_q <= load_entry(topavail_i, leftavail_i);
          end
        end
        S_LOADT: begin
          if (tstrobe_i) begin
            if (cnt_q == LAST_T) begin
              cnt_q   <= '0;
              state_q <= lav_q ? S_LOADL : S_CALC;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_LOADL: begin
          if (lstrobe_i) begin
            if (cnt_q == LAST_L) begin
              cnt_q   <= '0;
              state_q <= S_CALC;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_CALC: begin
          dc_q        <= dc_d;
          dcstrobeo_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= S_RESID;
        end
        S_RESID: begin
          if (strobei_i) begin
            datao_q   <= resid_d;
            strobeo_q <= 1'b1;
            if (cnt_q == LAST_R) begin
              cnt_q <= '0;
              if (chan_adv) begin
                cho_q   <= cho_q + 1'b1;
                state_q <= load_entry(tav_q, lav_q);
              end else begin
                state_q <= S_DONE;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign readyi_o    = (state_q == S_IDLE);
  assign strobeo_o   = strobeo_q;
  assign datao_o     = datao_q;
  assign dcstrobeo_o = dcstrobeo_q;
  assign dcdatao_o   = dc_q;
  assign baseo_o     = {4{dc_q}};
  assign cho_o       = cho_q;

endmodule
